// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared memory-bus types, arbiter state and register record.
// Revision : 1.0
// ============================================================================
package mem_arbiter_pkg;

  localparam int c_STARVE_LIMIT = 4;
  localparam int c_CNT_W        = 3;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_spec;
    logic        mem_fence;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  // Request slots live in mem_slot; the counter width is a module parameter.
  typedef struct packed {
    arb_state_t state;
    logic       kill;
    logic       overrun;
  } arbiter_reg_type;

  function automatic arbiter_reg_type init_arbiter_reg();
    arbiter_reg_type v;
    v.state   = IDLE;
    v.kill    = 1'b0;
    v.overrun = 1'b0;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_slot.sv
`default_nettype none
// ============================================================================
// Module   : mem_slot
// Purpose  : One-entry request holding register; a new load wins over clear.
// Revision : 1.0
// ============================================================================
module mem_slot
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_clear,
  input  mem_in_type i_req,
  output logic       o_full,
  output mem_in_type o_req
);

  logic       r_full;
  mem_in_type r_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_req  <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_req  <= i_req;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_req  = r_req;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one memory port between fetch and data, data-first with
//            a fetch starvation guard and speculative fetch redirect.
// Revision : 1.0
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = c_STARVE_LIMIT,
  parameter int CNT_W        = c_CNT_W
) (
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out,
  output logic        dmem_overrun
);

  localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(STARVE_LIMIT);

  arbiter_reg_type  r;
  arbiter_reg_type  rin;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic       w_pend_i;
  logic       w_pend_d;
  mem_in_type w_slot_i;
  mem_in_type w_slot_d;
  logic       w_grant_i;
  logic       w_grant_d;
  logic       w_redirect;
  logic       w_suppress;

  mem_slot u_slot_i (
    .clk     (clock),
    .rst_n   (reset),
    .i_load  (imem_in.mem_valid),
    .i_clear (w_grant_i),
    .i_req   (imem_in),
    .o_full  (w_pend_i),
    .o_req   (w_slot_i)
  );

  mem_slot u_slot_d (
    .clk     (clock),
    .rst_n   (reset),
    .i_load  (dmem_in.mem_valid),
    .i_clear (w_grant_d),
    .i_req   (dmem_in),
    .o_full  (w_pend_d),
    .o_req   (w_slot_d)
  );

  assign w_grant_d  = (r.state == IDLE) && w_pend_d && (!w_pend_i || (r_cnt < c_LIMIT));
  assign w_grant_i  = (r.state == IDLE) && w_pend_i && (!w_pend_d || (r_cnt >= c_LIMIT));
  assign w_redirect = imem_in.mem_valid && imem_in.mem_spec;
  // A redirect landing on the response cycle still makes that response stale.
  assign w_suppress = r.kill || w_redirect;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r     <= init_arbiter_reg();
      r_cnt <= '0;
    end else begin
      r     <= rin;
      r_cnt <= w_cnt_next;
    end
  end

  always_comb begin
    rin        = r;
    w_cnt_next = r_cnt;

    case (r.state)
      IDLE: begin
        if (w_grant_d) begin
          rin.state = BUSY_D;
        end else if (w_grant_i) begin
          rin.state = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_out.mem_ready) begin
          rin.state = IDLE;
        end
      end
      default: rin.state = IDLE;
    endcase

    rin.kill = (r.state == BUSY_I) && !mem_out.mem_ready && (r.kill || w_redirect);

    if (dmem_in.mem_valid && w_pend_d && !w_grant_d) begin
      rin.overrun = 1'b1;
    end

    if (!w_pend_i || w_grant_i) begin
      w_cnt_next = '0;
    end else if (w_grant_d && (r_cnt < c_LIMIT)) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    mem_in   = '0;
    imem_out = '0;
    dmem_out = '0;
    if (reset) begin
      if (w_grant_d) begin
        mem_in           = w_slot_d;
        mem_in.mem_valid = 1'b1;
        mem_in.mem_instr = 1'b0;
      end else if (w_grant_i) begin
        mem_in           = w_slot_i;
        mem_in.mem_valid = 1'b1;
        mem_in.mem_instr = 1'b1;
      end
      if ((r.state == BUSY_D) && mem_out.mem_ready) begin
        dmem_out = mem_out;
      end
      if ((r.state == BUSY_I) && mem_out.mem_ready && !w_suppress) begin
        imem_out = mem_out;
      end
    end
  end

  assign dmem_overrun = reset && r.overrun;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed scenarios plus randomized traffic against a
//            transaction-level reference model of the arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  mem_in_type  imem_in;
  mem_in_type  dmem_in;
  mem_in_type  mem_in;
  mem_out_type imem_out;
  mem_out_type dmem_out;
  mem_out_type mem_out;
  logic        dmem_overrun;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who owns the bus (0 none, 1 fetch, 2 data), waiting
  // requests, stale in-flight fetch, data grants while fetch waits.
  int         m_owner;
  bit         m_stale;
  bit         m_has_i;
  bit         m_has_d;
  mem_in_type m_req_i;
  mem_in_type m_req_d;
  int         m_waits;
  bit         m_ovr;
  bit         m_issued;

  mem_in_type  obs_mem_in;
  mem_out_type obs_iout;
  mem_out_type obs_dout;
  logic        obs_ovr;
  logic [7:0]  grant_log;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .reset        (reset),
    .clock        (clock),
    .imem_in      (imem_in),
    .imem_out     (imem_out),
    .dmem_in      (dmem_in),
    .dmem_out     (dmem_out),
    .mem_in       (mem_in),
    .mem_out      (mem_out),
    .dmem_overrun (dmem_overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic mem_in_type mk(input logic [31:0] a, input logic [31:0] wd,
                                    input logic [3:0] ws, input logic spec, input logic fence);
    mem_in_type q;
    q           = '0;
    q.mem_valid = 1'b1;
    q.mem_spec  = spec;
    q.mem_fence = fence;
    q.mem_addr  = a;
    q.mem_wdata = wd;
    q.mem_wstrb = ws;
    return q;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_stale = 0; m_has_i = 0; m_has_d = 0;
    m_req_i = '0; m_req_d = '0; m_waits = 0; m_ovr = 0; m_issued = 0;
  endtask

  // One clock cycle: drive, check mid-cycle against the model, advance model.
  task automatic step(input mem_in_type im, input mem_in_type dm, input logic mr,
                      input logic [31:0] rd, input logic rn);
    mem_in_type  e_mem;
    mem_out_type e_i;
    mem_out_type e_d;
    bit take_i, take_d, redirect;
    imem_in           = im;
    dmem_in           = dm;
    mem_out.mem_ready = mr;
    mem_out.mem_rdata = rd;
    reset             = rn;
    @(negedge clock);
    e_mem = '0; e_i = '0; e_d = '0; take_i = 0; take_d = 0;
    redirect = im.mem_valid && im.mem_spec;
    if (rn) begin
      // Data first, unless fetch has already watched LIMIT data grants go by.
      if (m_owner == 0 && m_has_d && !(m_has_i && m_waits >= LIMIT)) take_d = 1;
      else if (m_owner == 0 && m_has_i) take_i = 1;
      if (take_d) begin e_mem = m_req_d; e_mem.mem_valid = 1'b1; e_mem.mem_instr = 1'b0; end
      if (take_i) begin e_mem = m_req_i; e_mem.mem_valid = 1'b1; e_mem.mem_instr = 1'b1; end
      if (mr && m_owner == 2) begin e_d.mem_ready = 1'b1; e_d.mem_rdata = rd; end
      if (mr && m_owner == 1 && !m_stale && !redirect) begin
        e_i.mem_ready = 1'b1; e_i.mem_rdata = rd;
      end
    end
    obs_mem_in = mem_in;
    obs_iout   = imem_out;
    obs_dout   = dmem_out;
    obs_ovr    = dmem_overrun;
    chk("mem_in",   96'(obs_mem_in), 96'(e_mem));
    chk("imem_out", 96'(obs_iout),   96'(e_i));
    chk("dmem_out", 96'(obs_dout),   96'(e_d));
    chk("overrun",  96'(obs_ovr),    96'(rn && m_ovr));
    if (mem_in.mem_valid) grant_log = {grant_log[6:0], mem_in.mem_instr};
    m_issued = take_i || take_d;
    if (!rn) begin
      model_reset();
    end else begin
      m_stale = (m_owner == 1) && !mr && (m_stale || redirect);
      if (!m_has_i || take_i) m_waits = 0;
      else if (take_d && m_waits < LIMIT) m_waits++;
      if (dm.mem_valid && m_has_d && !take_d) m_ovr = 1;
      if (mr) m_owner = 0;
      if (take_d) begin m_owner = 2; m_has_d = 0; end
      if (take_i) begin m_owner = 1; m_has_i = 0; end
      if (im.mem_valid) begin m_has_i = 1; m_req_i = im; end
      if (dm.mem_valid) begin m_has_d = 1; m_req_d = dm; end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    mem_in_type nop;
    int lat;
    nop     = '0;
    imem_in = '0;
    dmem_in = '0;
    mem_out = '0;
    reset   = 1'b0;
    grant_log = '0;
    lat = 0;
    model_reset();
    @(posedge clock);
    #1;

    // Reset state
    step(nop, nop, 1'b0, 32'h0, 1'b0);
    step(nop, nop, 1'b1, 32'h5555_5555, 1'b0);
    chk("reset_mem_in", 96'(obs_mem_in), 96'h0);

    // Lone load
    step(nop, mk(32'h100, 32'h0, 4'h0, 1'b0, 1'b0), 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    chk("s1_issue", 96'({obs_mem_in.mem_valid, obs_mem_in.mem_instr, obs_mem_in.mem_addr}),
        96'({1'b1, 1'b0, 32'h100}));
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("s1_dresp", 96'(obs_dout), 96'({1'b1, 32'hDEAD_BEEF}));
    chk("s1_iquiet", 96'(obs_iout.mem_ready), 96'h0);

    // Simultaneous pulses: data first, fetch after the data response
    step(mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b0), mk(32'h200, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0),
         1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    chk("s2_dissue", 96'({obs_mem_in.mem_valid, obs_mem_in.mem_instr, obs_mem_in.mem_addr}),
        96'({1'b1, 1'b0, 32'h200}));
    step(nop, nop, 1'b1, 32'h1234_5678, 1'b1);
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    chk("s2_iissue", 96'({obs_mem_in.mem_valid, obs_mem_in.mem_instr, obs_mem_in.mem_addr}),
        96'({1'b1, 1'b1, 32'h0}));
    step(nop, nop, 1'b1, 32'h0BAD_F00D, 1'b1);
    chk("s2_iresp", 96'(obs_iout), 96'({1'b1, 32'h0BAD_F00D}));

    // Starvation guard
    grant_log = '0;
    step(mk(32'h300, 32'h0, 4'h0, 1'b0, 1'b0), mk(32'h1000, 32'h0, 4'h0, 1'b0, 1'b0),
         1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(nop, mk(32'h1004 + 32'(k * 4), 32'h0, 4'h0, 1'b0, 1'b0), 1'b0, 32'h0, 1'b1);
      step(nop, nop, 1'b1, 32'(k), 1'b1);
    end
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b1, 32'h77, 1'b1);
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b1, 32'h88, 1'b1);
    chk("s3_order", 96'(grant_log[5:0]), 96'(6'b000010));
    chk("s3_no_ovr", 96'(obs_ovr), 96'h0);

    // Redirect while a fetch is in flight
    step(mk(32'h40, 32'h0, 4'h0, 1'b0, 1'b0), nop, 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    step(mk(32'h80, 32'h0, 4'h0, 1'b1, 1'b0), nop, 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b1, 32'h1111_1111, 1'b1);
    chk("s4_killed", 96'(obs_iout.mem_ready), 96'h0);
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    chk("s4_reissue", 96'({obs_mem_in.mem_valid, obs_mem_in.mem_instr, obs_mem_in.mem_addr}),
        96'({1'b1, 1'b1, 32'h80}));
    step(nop, nop, 1'b1, 32'h2222_2222, 1'b1);
    chk("s4_resp", 96'(obs_iout), 96'({1'b1, 32'h2222_2222}));

    // Overrun while fetch owns the bus
    step(mk(32'h500, 32'h0, 4'h0, 1'b0, 1'b0), nop, 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    step(nop, mk(32'h600, 32'h0, 4'h0, 1'b0, 1'b0), 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    step(nop, mk(32'h700, 32'hAA, 4'h1, 1'b0, 1'b0), 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b1, 32'h3, 1'b1);
    chk("s5_ovr", 96'(obs_ovr), 96'h1);
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    chk("s5_second", 96'({obs_mem_in.mem_valid, obs_mem_in.mem_addr}), 96'({1'b1, 32'h700}));
    step(nop, nop, 1'b1, 32'h4, 1'b1);

    // Reset in the middle of a data transaction
    step(nop, mk(32'h900, 32'h0, 4'h0, 1'b0, 1'b1), 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b0, 32'h0, 1'b0);
    step(nop, nop, 1'b1, 32'h9999_9999, 1'b1);
    chk("s6_ignored", 96'(obs_dout), 96'h0);
    chk("s6_ovr_clr", 96'(obs_ovr), 96'h0);
    step(nop, mk(32'h100, 32'h0, 4'h0, 1'b0, 1'b0), 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    chk("s6_issue", 96'({obs_mem_in.mem_valid, obs_mem_in.mem_addr}), 96'({1'b1, 32'h100}));
    step(nop, nop, 1'b0, 32'h0, 1'b1);
    step(nop, nop, 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("s6_resp", 96'(obs_dout), 96'({1'b1, 32'hDEAD_BEEF}));

    // Randomized traffic; the bench plays memory with 1..3 cycle latency
    for (int n = 0; n < 1500; n++) begin
      mem_in_type im;
      mem_in_type dm;
      logic       mr;
      logic       rn;
      im = '0;
      dm = '0;
      rn = ($urandom_range(0, 299) != 0);
      mr = (m_owner != 0) && (lat == 0);
      if ($urandom_range(0, 6) == 0)
        im = mk($urandom & 32'hFFFF_FFFC, 32'h0, 4'h0, 1'($urandom_range(0, 1)), 1'b0);
      if (mr && m_owner == 1 && !m_stale) im.mem_spec = 1'b0;
      if ($urandom_range(0, 4) == 0)
        dm = mk($urandom, $urandom, 4'($urandom), 1'b0, 1'($urandom_range(0, 7) == 0));
      step(im, dm, mr, $urandom, rn);
      if (m_issued) lat = $urandom_range(0, 2);
      else if (lat > 0) lat--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
